// File: rtl/vc_dest_arbiter.sv
// ============================================================================
// Module   : vc_dest_arbiter
// Purpose  : Pops words from two virtual-channel FIFOs (VC0 has strict
//            priority over VC1) and pushes each word into destination FIFO
//            D0 or D1, chosen by bit 8 of the word. Pops stop while either
//            destination is almost full, and the block halts for good
//            (until reset) when any FIFO reports an error. A per-destination
//            counter tracks pushed words.
// Ports    : clk, reset (async, active-high)
//            fifo_empty_vc0/1, data_vc0/1   - source FIFO status / read data
//            fifo_pause_d0/1, fifo_error    - destination back-pressure, error
//            pop_vc0/1                      - combinational pop strobes
//            push_d0/1, data_out            - registered push strobes + word
//            cnt_d0/1                       - wrapping push counters
//            idle_out/active_out/error_out  - state decodes
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vc_dest_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_vc0,
  input  logic [DATA_SIZE-1:0] data_vc1,
  input  logic                 fifo_pause_d0,
  input  logic                 fifo_pause_d1,
  input  logic                 fifo_error,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [CNT_SIZE-1:0]  cnt_d0,
  output logic [CNT_SIZE-1:0]  cnt_d1,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 sel_q;      // source of the word in flight: 0 = VC0, 1 = VC1
  logic                 valid_q;    // a pop was issued last cycle
  logic                 push_d0_q, push_d1_q;
  logic [DATA_SIZE-1:0] data_q;
  logic [CNT_SIZE-1:0]  cnt_d0_q, cnt_d1_q;

  logic                 can_pop;
  logic                 any_pop;
  logic [DATA_SIZE-1:0] word;

  // Both pauses gate the pop: the destination is only known once the word
  // has been read, so either destination being full must block.
  assign can_pop = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                   !fifo_pause_d0 && !fifo_pause_d1;
  assign pop_vc0 = can_pop && !fifo_empty_vc0;
  assign pop_vc1 = can_pop && fifo_empty_vc0 && !fifo_empty_vc1;
  assign any_pop = pop_vc0 || pop_vc1;

  // Read data arrives one cycle after the pop, selected by the flight tag.
  assign word = sel_q ? data_vc1 : data_vc0;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_pop) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Drained only when nothing is queued, popping, or still in flight.
        if (fifo_empty_vc0 && fifo_empty_vc1 && !any_pop &&
            !valid_q && !push_d0_q && !push_d1_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
    // An error overrides every other transition; INIT ignores it.
    if (fifo_error && (state_q != ST_INIT)) begin
      state_d = ST_ERROR;
    end
  end

  // ------------------------------------------------------------------
  // Flight and output stages. Words already in flight keep moving in
  // ERROR; only new pops are suppressed (via can_pop).
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= 1'b0;
      valid_q   <= 1'b0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
    end else begin
      sel_q   <= pop_vc1;
      valid_q <= any_pop;
      if (valid_q) begin
        data_q    <= word;
        push_d0_q <= !word[8];
        push_d1_q <= word[8];
      end else begin
        push_d0_q <= 1'b0;
        push_d1_q <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Push counters (wrap naturally at 2^CNT_SIZE)
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else begin
      if (push_d0_q) begin
        cnt_d0_q <= cnt_d0_q + CNT_SIZE'(1);
      end
      if (push_d1_q) begin
        cnt_d1_q <= cnt_d1_q + CNT_SIZE'(1);
      end
    end
  end

  assign push_d0    = push_d0_q;
  assign push_d1    = push_d1_q;
  assign data_out   = data_q;
  assign cnt_d0     = cnt_d0_q;
  assign cnt_d1     = cnt_d1_q;
  assign idle_out   = (state_q == ST_IDLE);
  assign active_out = (state_q == ST_ACTIVE);
  assign error_out  = (state_q == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_vc_dest_arbiter.sv
// ============================================================================
// Module   : tb_vc_dest_arbiter
// Purpose  : Self-checking bench for vc_dest_arbiter. Source FIFOs are
//            modelled as queues; a reference model predicts pops from the
//            priority/pause rules and schedules each popped word to appear
//            on the destination side exactly two cycles later.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vc_dest_arbiter;

  localparam int DW = 10;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty_vc0, fifo_empty_vc1;
  logic [DW-1:0] data_vc0, data_vc1;
  logic          fifo_pause_d0, fifo_pause_d1, fifo_error;
  logic          pop_vc0, pop_vc1, push_d0, push_d1;
  logic [DW-1:0] data_out;
  logic [CW-1:0] cnt_d0, cnt_d1;
  logic          idle_out, active_out, error_out;

  vc_dest_arbiter #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty_vc0 (fifo_empty_vc0),
    .fifo_empty_vc1 (fifo_empty_vc1),
    .data_vc0       (data_vc0),
    .data_vc1       (data_vc1),
    .fifo_pause_d0  (fifo_pause_d0),
    .fifo_pause_d1  (fifo_pause_d1),
    .fifo_error     (fifo_error),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_out       (data_out),
    .cnt_d0         (cnt_d0),
    .cnt_d1         (cnt_d1),
    .idle_out       (idle_out),
    .active_out     (active_out),
    .error_out      (error_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    int          cyc;
    logic [DW-1:0] w;
  } ev_t;

  localparam int M_INIT = 0, M_IDLE = 1, M_ACTIVE = 2, M_ERROR = 3;

  ev_t           sched[$];          // words due on the destination side
  logic [DW-1:0] vc0_q[$], vc1_q[$];
  int            cyc;
  int            last_pop;
  int            m_st;
  int            m_cnt0, m_cnt1;
  logic [DW-1:0] m_dout;
  int            n_vec = 0;
  int            n_err = 0;

  // Advances one clock: checks pops mid-cycle, then registered outputs
  // and state decodes just after the edge. Entered/left at posedge+1.
  task automatic run_cycle();
    bit            can, ep0, ep1, both_empty, xp0, xp1;
    int            nst;
    logic [DW-1:0] w;
    ev_t           e;
    w = '0;
    fifo_empty_vc0 = (vc0_q.size() == 0);
    fifo_empty_vc1 = (vc1_q.size() == 0);
    #4;
    can = ((m_st == M_IDLE) || (m_st == M_ACTIVE)) && !fifo_pause_d0 && !fifo_pause_d1;
    ep0 = can && !fifo_empty_vc0;
    ep1 = can && fifo_empty_vc0 && !fifo_empty_vc1;
    n_vec++;
    if (pop_vc0 !== ep0 || pop_vc1 !== ep1) begin
      n_err++;
      $display("FAIL pops cyc=%0d: got vc0=%b vc1=%b, expected vc0=%b vc1=%b",
               cyc, pop_vc0, pop_vc1, ep0, ep1);
    end
    both_empty = fifo_empty_vc0 && fifo_empty_vc1;
    nst = m_st;
    case (m_st)
      M_INIT:   nst = M_IDLE;
      M_IDLE:   if (ep0 || ep1) nst = M_ACTIVE;
      M_ACTIVE: if (both_empty && (cyc - last_pop) > 2) nst = M_IDLE;
      default:  nst = M_ERROR;
    endcase
    if (fifo_error && m_st != M_INIT) nst = M_ERROR;
    if (ep0) w = vc0_q.pop_front();
    else if (ep1) w = vc1_q.pop_front();
    if (ep0 || ep1) begin
      sched.push_back('{cyc: cyc + 2, w: w});
      last_pop = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ep0) data_vc0 = w;
    if (ep1) data_vc1 = w;
    m_st = nst;
    xp0 = 1'b0;
    xp1 = 1'b0;
    if (sched.size() > 0 && sched[0].cyc == cyc) begin
      e      = sched.pop_front();
      m_dout = e.w;
      xp0    = !e.w[8];
      xp1    = e.w[8];
    end
    n_vec++;
    if (push_d0 !== xp0 || push_d1 !== xp1 || data_out !== m_dout) begin
      n_err++;
      $display("FAIL push cyc=%0d: got d0=%b d1=%b data=%h, expected d0=%b d1=%b data=%h",
               cyc, push_d0, push_d1, data_out, xp0, xp1, m_dout);
    end
    n_vec++;
    if (cnt_d0 !== m_cnt0[CW-1:0] || cnt_d1 !== m_cnt1[CW-1:0]) begin
      n_err++;
      $display("FAIL counters cyc=%0d: got d0=%0d d1=%0d, expected d0=%0d d1=%0d",
               cyc, cnt_d0, cnt_d1, m_cnt0, m_cnt1);
    end
    m_cnt0 = (m_cnt0 + int'(xp0)) & 255;
    m_cnt1 = (m_cnt1 + int'(xp1)) & 255;
    n_vec++;
    if (idle_out !== (m_st == M_IDLE) || active_out !== (m_st == M_ACTIVE) ||
        error_out !== (m_st == M_ERROR)) begin
      n_err++;
      $display("FAIL state cyc=%0d: got idle=%b active=%b error=%b, expected state %0d",
               cyc, idle_out, active_out, error_out, m_st);
    end
  endtask

  // Holds reset across one edge, clears sources and model, releases at posedge+1.
  task automatic do_reset();
    reset          = 1'b1;
    fifo_error     = 1'b0;
    fifo_pause_d0  = 1'b0;
    fifo_pause_d1  = 1'b0;
    vc0_q.delete();
    vc1_q.delete();
    sched.delete();
    fifo_empty_vc0 = 1'b1;
    fifo_empty_vc1 = 1'b1;
    data_vc0       = '0;
    data_vc1       = '0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    m_st     = M_INIT;
    last_pop = -100;
    m_cnt0   = 0;
    m_cnt1   = 0;
    m_dout   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_vec++;
    if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0 || push_d0 !== 1'b0 || push_d1 !== 1'b0 ||
        data_out !== '0 || cnt_d0 !== '0 || cnt_d1 !== '0 ||
        idle_out !== 1'b0 || active_out !== 1'b0 || error_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got pops=%b%b push=%b%b data=%h cnt=%0d/%0d st=%b%b%b, expected all 0",
               pop_vc0, pop_vc1, push_d0, push_d1, data_out, cnt_d0, cnt_d1,
               idle_out, active_out, error_out);
    end
    do_reset();
    n_vec++;
    if (idle_out !== 1'b0 || active_out !== 1'b0 || error_out !== 1'b0) begin
      n_err++;
      $display("FAIL init_state: got idle=%b active=%b error=%b, expected 0 0 0",
               idle_out, active_out, error_out);
    end
    run_cycle();
    n_vec++;
    if (idle_out !== 1'b1 || cnt_d0 !== '0 || cnt_d1 !== '0) begin
      n_err++;
      $display("FAIL idle_after_init: got idle=%b cnt=%0d/%0d, expected 1 0/0",
               idle_out, cnt_d0, cnt_d1);
    end
  endtask

  task automatic test_vc0_stream();
    vc0_q.push_back(10'h003);
    vc0_q.push_back(10'h104);
    vc0_q.push_back(10'h005);
    repeat (7) run_cycle();
    n_vec++;
    if (cnt_d0 !== 8'd2 || cnt_d1 !== 8'd1 || idle_out !== 1'b1) begin
      n_err++;
      $display("FAIL vc0_stream_end: got cnt=%0d/%0d idle=%b, expected 2/1 idle=1",
               cnt_d0, cnt_d1, idle_out);
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 4; i++) vc0_q.push_back(DW'(10'h010 + i));
    for (int i = 0; i < 3; i++) vc1_q.push_back(DW'(10'h120 + i));
    repeat (12) run_cycle();
    n_vec++;
    if (idle_out !== 1'b1 || cnt_d0 !== 8'd6 || cnt_d1 !== 8'd4) begin
      n_err++;
      $display("FAIL priority_end: got idle=%b cnt=%0d/%0d, expected 1 6/4",
               idle_out, cnt_d0, cnt_d1);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 8; i++) vc0_q.push_back(DW'((i % 2) ? (10'h140 + i) : (10'h040 + i)));
    repeat (2) run_cycle();
    fifo_pause_d1 = 1'b1;
    repeat (3) run_cycle();
    fifo_pause_d1 = 1'b0;
    repeat (12) run_cycle();
    n_vec++;
    if (idle_out !== 1'b1 || cnt_d0 !== 8'd10 || cnt_d1 !== 8'd8) begin
      n_err++;
      $display("FAIL pause_end: got idle=%b cnt=%0d/%0d, expected 1 10/8",
               idle_out, cnt_d0, cnt_d1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2, 0) == 0) vc0_q.push_back(DW'($urandom));
      if ($urandom_range(3, 0) == 0) vc1_q.push_back(DW'($urandom));
      fifo_pause_d0 = ($urandom_range(5, 0) == 0);
      fifo_pause_d1 = ($urandom_range(5, 0) == 0);
      run_cycle();
    end
    fifo_pause_d0 = 1'b0;
    fifo_pause_d1 = 1'b0;
    repeat (60) run_cycle();
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    run_cycle();
    for (int i = 0; i < 260; i++) vc0_q.push_back(DW'($urandom) & 10'h2FF);
    repeat (266) run_cycle();
    n_vec++;
    if (cnt_d0 !== 8'd4 || cnt_d1 !== 8'd0) begin
      n_err++;
      $display("FAIL wrap: got cnt=%0d/%0d, expected 4/0", cnt_d0, cnt_d1);
    end
    for (int i = 0; i < 5; i++) vc0_q.push_back(DW'(10'h020 + i));
    repeat (3) run_cycle();
    n_vec++;
    if (push_d0 !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_push: got %b, expected 1", push_d0);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (push_d0 !== 1'b0 || push_d1 !== 1'b0 || pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0 ||
        idle_out !== 1'b0 || active_out !== 1'b0 || cnt_d0 !== '0) begin
      n_err++;
      $display("FAIL midstream_reset: got push=%b%b pops=%b%b idle=%b active=%b cnt=%0d, expected all 0",
               push_d0, push_d1, pop_vc0, pop_vc1, idle_out, active_out, cnt_d0);
    end
    do_reset();
    repeat (3) run_cycle();
  endtask

  task automatic test_error();
    do_reset();
    run_cycle();
    vc0_q.push_back(10'h1AA);
    run_cycle();
    fifo_error = 1'b1;
    run_cycle();
    fifo_error = 1'b0;
    vc0_q.push_back(10'h011);
    vc0_q.push_back(10'h112);
    vc1_q.push_back(10'h013);
    repeat (6) run_cycle();
    n_vec++;
    if (error_out !== 1'b1 || cnt_d1 !== 8'd1 || cnt_d0 !== 8'd0) begin
      n_err++;
      $display("FAIL error_sticky: got error=%b cnt=%0d/%0d, expected 1 0/1",
               error_out, cnt_d0, cnt_d1);
    end
    do_reset();
    n_vec++;
    if (error_out !== 1'b0) begin
      n_err++;
      $display("FAIL error_clear: got error=%b, expected 0", error_out);
    end
    repeat (2) run_cycle();
  endtask

  initial begin
    cyc = 0;
    last_pop = -100;
    m_st = M_INIT;
    m_cnt0 = 0;
    m_cnt1 = 0;
    m_dout = '0;
    fifo_error = 1'b0;
    fifo_pause_d0 = 1'b0;
    fifo_pause_d1 = 1'b0;
    fifo_empty_vc0 = 1'b1;
    fifo_empty_vc1 = 1'b1;
    data_vc0 = '0;
    data_vc1 = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_vc0_stream();
    test_priority();
    test_pause();
    test_random();
    test_wrap_and_reset();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
